// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arb_pkg
// Description : Shared types and constants for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_STALL = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_RESP       = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        ISSUE      = ST_ISSUE,
        WAIT_STALL = ST_WAIT_STALL,
        WAIT_DONE  = ST_WAIT_DONE,
        RESP       = ST_RESP
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Access size/sign codes understood by the data memory and the decoder
    localparam logic [3:0] SM_BYTE   = 4'b0001;
    localparam logic [3:0] SM_HALF   = 4'b0011;
    localparam logic [3:0] SM_WORD   = 4'b1111;
    localparam logic [3:0] SM_BYTE_U = 4'b1001;
    localparam logic [3:0] SM_HALF_U = 4'b1011;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sign_mask;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick2
// Description : Combinational two-way winner select, fixed or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick2
    import data_mem_arb_pkg::*;
#(
    parameter int ARB_MODE = 1
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = M0;
        if (ARB_MODE == 0) begin
            winner_o = req0_i ? M0 : M1;
        end else if (req0_i && req1_i) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = req1_i ? M1 : M0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-master arbiter/sequencer for the stalling data memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_sign_mask,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_sign_mask,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    mem_req_t    pay_q, pay_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  done_q, done_d;

    logic        pick_valid;
    logic        pick_winner;
    mem_req_t    m0_pay;
    mem_req_t    m1_pay;
    logic [7:0]  cnt_inc;
    logic [1:0]  done_sel;

    assign m0_pay   = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, sign_mask: m0_sign_mask};
    assign m1_pay   = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, sign_mask: m1_sign_mask};
    assign cnt_inc  = cnt_q + 8'd1;
    assign done_sel = (grant_q == M1) ? 2'b10 : 2'b01;

    arb_pick2 #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pay_d        = pay_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        done_d       = 2'b00;

        case (state_q)
            IDLE: begin
                // A busy memory may still be finishing an access orphaned by reset
                if (pick_valid && !mem_clk_stall) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    pay_d        = (pick_winner == M1) ? m1_pay : m0_pay;
                    rd_d         = ~pay_d.we;
                    wr_d         = pay_d.we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_STALL;
            end
            WAIT_STALL: begin
                cnt_d = cnt_inc;
                if (cnt_inc == TIMEOUT_LIM) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = done_sel;
                    state_d = RESP;
                end else if (mem_clk_stall) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (!mem_clk_stall) begin
                    rdata_d = pay_q.we ? 32'd0 : mem_read_data;
                    err_d   = 1'b0;
                    done_d  = done_sel;
                    state_d = RESP;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = done_sel;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= M0;
            last_grant_q <= M1;
            cnt_q        <= '0;
            pay_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            done_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            pay_q        <= pay_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            done_q       <= done_d;
        end
    end

    assign mem_addr       = pay_q.addr;
    assign mem_write_data = pay_q.wdata;
    assign mem_sign_mask  = pay_q.sign_mask;
    assign mem_memread    = rd_q;
    assign mem_memwrite   = wr_q;

    // Response fields are only meaningful alongside the done pulse
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_err   = done_q[0] & err_q;
    assign m1_err   = done_q[1] & err_q;
    assign m0_rdata = done_q[0] ? rdata_q : 32'd0;
    assign m1_rdata = done_q[1] ? rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Scoreboard bench; instance 0 round-robin, instance 1 fixed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    typedef struct packed {
        logic        m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        model_rst;

    logic        m0_req   [2];
    logic        m0_we    [2];
    logic [31:0] m0_addr  [2];
    logic [31:0] m0_wdata [2];
    logic [3:0]  m0_mask  [2];
    logic [31:0] m0_rdata [2];
    logic        m0_done  [2];
    logic        m0_err   [2];
    logic        m1_req   [2];
    logic        m1_we    [2];
    logic [31:0] m1_addr  [2];
    logic [31:0] m1_wdata [2];
    logic [3:0]  m1_mask  [2];
    logic [31:0] m1_rdata [2];
    logic        m1_done  [2];
    logic        m1_err   [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_mask  [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [31:0] mem_rdata [2];
    logic        mem_stall [2];

    int          scnt     [2];
    int          hold     [2];
    bit          no_stall [2];
    logic        prev_strobe [2];
    int          rd_cnt   [2];
    int          wr_cnt   [2];

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          n_vec;
    int          n_miss;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        data_mem_arbiter #(
            .ARB_MODE       (i == 0 ? 1 : 0),
            .TIMEOUT_CYCLES (15)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .m0_req         (m0_req[i]),
            .m0_we          (m0_we[i]),
            .m0_addr        (m0_addr[i]),
            .m0_wdata       (m0_wdata[i]),
            .m0_sign_mask   (m0_mask[i]),
            .m0_rdata       (m0_rdata[i]),
            .m0_done        (m0_done[i]),
            .m0_err         (m0_err[i]),
            .m1_req         (m1_req[i]),
            .m1_we          (m1_we[i]),
            .m1_addr        (m1_addr[i]),
            .m1_wdata       (m1_wdata[i]),
            .m1_sign_mask   (m1_mask[i]),
            .m1_rdata       (m1_rdata[i]),
            .m1_done        (m1_done[i]),
            .m1_err         (m1_err[i]),
            .mem_addr       (mem_addr[i]),
            .mem_write_data (mem_wdata[i]),
            .mem_sign_mask  (mem_mask[i]),
            .mem_memread    (mem_rd[i]),
            .mem_memwrite   (mem_wr[i]),
            .mem_read_data  (mem_rdata[i]),
            .mem_clk_stall  (mem_stall[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory model: stall rises the edge after a strobe and holds for hold[k] edges
    always_comb begin
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = (mem_addr[k] == 32'h1004) ? 32'hDEADBEEF : {16'hC0DE, mem_addr[k][15:0]};
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (model_rst) begin
                mem_stall[k] <= 1'b0;
                scnt[k]      <= 0;
            end else if (mem_rd[k] || mem_wr[k]) begin
                if (!no_stall[k]) begin
                    mem_stall[k] <= 1'b1;
                    scnt[k]      <= hold[k] - 1;
                end
            end else if (mem_stall[k]) begin
                if (scnt[k] == 0) mem_stall[k] <= 1'b0;
                else              scnt[k]      <= scnt[k] - 1;
            end
        end
    end

    // Monitor: strobe protocol and scoreboard pop on every done pulse
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t got;
            exp_t e;
            if (mem_rd[k] || mem_wr[k]) begin
                chk($sformatf("strobe_proto%0d", k),
                    {93'd0, mem_rd[k] & mem_wr[k], prev_strobe[k], mem_stall[k]}, 96'd0);
            end
            prev_strobe[k] = mem_rd[k] | mem_wr[k];
            rd_cnt[k] += int'(mem_rd[k]);
            wr_cnt[k] += int'(mem_wr[k]);
            if (m0_done[k] || m1_done[k]) begin
                got.m     = m1_done[k];
                got.rdata = m1_done[k] ? m1_rdata[k] : m0_rdata[k];
                got.err   = m1_done[k] ? m1_err[k] : m0_err[k];
                if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    chk($sformatf("unexpected_done%0d", k), {62'd0, got}, 96'd0);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("resp%0d", k),
                        {60'd0, got, m0_done[k] & m1_done[k], m1_done[k] ? m0_err[k] : m1_err[k]},
                        {60'd0, e, 2'b00});
                end
            end
        end
    end

    // Drives one transaction from master m of instance k; call at a negedge.
    task automatic txn(input int k, input int m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input int drop_after, output int lat);
        bit d;
        if (m == 0) begin
            m0_we[k] = we; m0_addr[k] = addr; m0_wdata[k] = wdata; m0_mask[k] = mask; m0_req[k] = 1'b1;
        end else begin
            m1_we[k] = we; m1_addr[k] = addr; m1_wdata[k] = wdata; m1_mask[k] = mask; m1_req[k] = 1'b1;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == drop_after) begin
                if (m == 0) m0_req[k] = 1'b0; else m1_req[k] = 1'b0;
            end
            d = (m == 0) ? m0_done[k] : m1_done[k];
            if (d) break;
            if (lat > 100) begin
                n_vec++;
                n_miss++;
                $display("FAIL txn_timeout inst%0d m%0d: no done after %0d cycles, required done", k, m, lat);
                break;
            end
        end
        if (m == 0) m0_req[k] = 1'b0; else m1_req[k] = 1'b0;
    endtask

    int   lat;
    int   lat_a, lat_b, lat_c, lat_d;
    int   rd_base, wr_base;
    bit   hold_ok;
    bit   seen_done;

    initial begin
        rst = 1'b1;
        model_rst = 1'b1;
        n_vec = 0;
        n_miss = 0;
        for (int k = 0; k < 2; k++) begin
            m0_req[k] = 0; m0_we[k] = 0; m0_addr[k] = 0; m0_wdata[k] = 0; m0_mask[k] = 0;
            m1_req[k] = 0; m1_we[k] = 0; m1_addr[k] = 0; m1_wdata[k] = 0; m1_mask[k] = 0;
            hold[k] = 2; no_stall[k] = 0; prev_strobe[k] = 0; rd_cnt[k] = 0; wr_cnt[k] = 0;
        end
        #1;
        chk("rst_mem", {mem_addr[0], mem_wdata[0], 26'd0, mem_mask[0], mem_rd[0], mem_wr[0]}, 96'd0);
        chk("rst_flags", {92'd0, m0_done[0], m0_err[0], m1_done[0], m1_err[0]}, 96'd0);
        chk("rst_rdata", {32'd0, m0_rdata[0], m1_rdata[0]}, 96'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_rst = 1'b0;
        @(negedge clk);

        // Both masters streaming, two reads each, on both arbitration modes
        exp_q0.push_back('{m: 1'b0, rdata: 32'hC0DE0100, err: 1'b0});
        exp_q0.push_back('{m: 1'b1, rdata: 32'hC0DE0200, err: 1'b0});
        exp_q0.push_back('{m: 1'b0, rdata: 32'hC0DE0104, err: 1'b0});
        exp_q0.push_back('{m: 1'b1, rdata: 32'hC0DE0204, err: 1'b0});
        exp_q1.push_back('{m: 1'b0, rdata: 32'hC0DE0100, err: 1'b0});
        exp_q1.push_back('{m: 1'b0, rdata: 32'hC0DE0104, err: 1'b0});
        exp_q1.push_back('{m: 1'b1, rdata: 32'hC0DE0200, err: 1'b0});
        exp_q1.push_back('{m: 1'b1, rdata: 32'hC0DE0204, err: 1'b0});
        fork
            begin
                txn(0, 0, 1'b0, 32'h100, 32'h0, 4'hF, 0, lat_a);
                txn(0, 0, 1'b0, 32'h104, 32'h0, 4'hF, 0, lat_a);
            end
            begin
                txn(0, 1, 1'b0, 32'h200, 32'h0, 4'hF, 0, lat_b);
                txn(0, 1, 1'b0, 32'h204, 32'h0, 4'hF, 0, lat_b);
            end
            begin
                txn(1, 0, 1'b0, 32'h100, 32'h0, 4'hF, 0, lat_c);
                txn(1, 0, 1'b0, 32'h104, 32'h0, 4'hF, 0, lat_c);
            end
            begin
                txn(1, 1, 1'b0, 32'h200, 32'h0, 4'hF, 0, lat_d);
                txn(1, 1, 1'b0, 32'h204, 32'h0, 4'hF, 0, lat_d);
            end
        join
        repeat (2) @(negedge clk);
        chk("arb_drained", {32'd0, 32'(exp_q0.size()), 32'(exp_q1.size())}, 96'd0);

        // Word read with nominal stall: done 5 cycles after request sampled
        rd_base = rd_cnt[0]; wr_base = wr_cnt[0];
        exp_q0.push_back('{m: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
        txn(0, 0, 1'b0, 32'h1004, 32'h0, 4'hF, 0, lat);
        chk("rd_latency", 96'(lat), 96'd5);
        repeat (2) @(negedge clk);
        chk("rd_strobes", {32'd0, 32'(rd_cnt[0] - rd_base), 32'(wr_cnt[0] - wr_base)}, {32'd0, 32'd1, 32'd0});

        // Byte write from m1: payload must stay put until the response
        rd_base = rd_cnt[0]; wr_base = wr_cnt[0];
        hold_ok = 1'b1;
        seen_done = 1'b0;
        exp_q0.push_back('{m: 1'b1, rdata: 32'h0, err: 1'b0});
        fork
            txn(0, 1, 1'b1, 32'h2000, 32'hA5, 4'h1, 0, lat);
            begin
                for (int c = 0; c < 20 && !mem_wr[0]; c++) @(negedge clk);
                for (int c = 0; c < 20; c++) begin
                    if (mem_addr[0] !== 32'h2000 || mem_wdata[0] !== 32'hA5 || mem_mask[0] !== 4'h1)
                        hold_ok = 1'b0;
                    if (m1_done[0]) begin
                        seen_done = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
            end
        join
        chk("wr_hold", {94'd0, hold_ok, seen_done}, {94'd0, 2'b11});
        chk("wr_latency", 96'(lat), 96'd5);
        repeat (2) @(negedge clk);
        chk("wr_strobes", {32'd0, 32'(rd_cnt[0] - rd_base), 32'(wr_cnt[0] - wr_base)}, {32'd0, 32'd0, 32'd1});

        // Memory never stalls: abort after TIMEOUT_CYCLES with err and zero data
        no_stall[0] = 1'b1;
        exp_q0.push_back('{m: 1'b0, rdata: 32'h0, err: 1'b1});
        txn(0, 0, 1'b0, 32'h3000, 32'h0, 4'hF, 0, lat);
        chk("timeout_latency", 96'(lat), 96'd17);
        no_stall[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Request dropped right after grant still completes, once
        rd_base = rd_cnt[0];
        exp_q0.push_back('{m: 1'b0, rdata: 32'hC0DE0040, err: 1'b0});
        txn(0, 0, 1'b0, 32'h40, 32'h0, 4'hF, 1, lat);
        chk("drop_latency", 96'(lat), 96'd5);
        repeat (8) @(negedge clk);
        chk("drop_single_issue", 96'(rd_cnt[0] - rd_base), 96'd1);

        // Reset in WAIT_DONE with a long stall: orphaned access, deferred re-issue
        hold[0] = 4;
        rd_base = rd_cnt[0];
        exp_q0.push_back('{m: 1'b1, rdata: 32'hC0DE0080, err: 1'b0});
        fork
            txn(0, 1, 1'b0, 32'h80, 32'h0, 4'hF, 0, lat);
            begin
                repeat (3) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("midrst_mem", {mem_addr[0], mem_wdata[0], 26'd0, mem_mask[0], mem_rd[0], mem_wr[0]}, 96'd0);
                chk("midrst_resp", {m1_rdata[0], 60'd0, m0_done[0], m1_done[0], m0_err[0], m1_err[0]}, 96'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        chk("midrst_latency", 96'(lat), 96'd13);
        hold[0] = 2;
        repeat (2) @(negedge clk);
        chk("midrst_issues", 96'(rd_cnt[0] - rd_base), 96'd2);

        chk("final_drained", {32'd0, 32'(exp_q0.size()), 32'(exp_q1.size())}, 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
